// File: rtl/snn_pkg.sv
// Shared sizes, FSM encoding and LUT addressing for the digit-recognition core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snn_pkg;

    localparam int N_IN   = 784;  // 28x28 1-bit pixels
    localparam int N_HID  = 32;   // hidden neurons
    localparam int N_OUT  = 10;   // output neurons (digits)
    localparam int W_W    = 8;    // weight / activation width
    localparam int ACC_W  = 26;   // signed MAC accumulator width
    localparam int LUT_AW = 11;   // sigmoid LUT address width (rectified value width)

    localparam int PIX_AW = 10;   // pixel address, 0..783
    localparam int HID_AW = 5;    // hidden index, 0..31
    localparam int OUT_AW = 4;    // digit index, 0..9
    localparam int HW_AW  = 15;   // hidden weight ROM address, 0..25087
    localparam int OW_AW  = 9;    // output weight ROM address, 0..319

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HID_MAC = 3'd1,
        S_HID_ACT = 3'd2,
        S_OUT_MAC = 3'd3,
        S_OUT_ACT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Rectified value is two's complement; the LUT is indexed by value+1024,
    // which is the same as inverting the sign bit.
    function automatic logic [LUT_AW-1:0] lut_addr(input logic [LUT_AW-1:0] sat);
        return {~sat[LUT_AW-1], sat[LUT_AW-2:0]};
    endfunction

endpackage

// File: rtl/snn_mac.sv
// Signed 8x8 multiply-accumulate into a 26-bit accumulator with 11-bit saturating rectifier.
// Latency: product lands in the accumulator on the edge where i_en=1; o_sat is combinational from it.
// Backpressure: none, one product per enabled cycle.
module snn_mac
    import snn_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic signed [W_W-1:0] i_w,
    input  logic signed [W_W-1:0] i_x,
    output logic [LUT_AW-1:0]     o_sat
);

    localparam int SAT_LSB = 7;
    localparam int SAT_MSB = SAT_LSB + LUT_AW - 1;

    logic signed [2*W_W-1:0] w_prod;
    logic signed [ACC_W-1:0] r_acc;
    logic                    w_pos_ovf;
    logic                    w_neg_ovf;

    assign w_prod = i_w * i_x;

    // Clear wins over enable so a new neuron always starts from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + {{(ACC_W-2*W_W){w_prod[2*W_W-1]}}, w_prod};
        end
    end

    // Value fits the 11-bit window only when bits 25..17 all agree.
    assign w_pos_ovf = ~r_acc[ACC_W-1] &  (|r_acc[ACC_W-2:SAT_MSB]);
    assign w_neg_ovf =  r_acc[ACC_W-1] & ~(&r_acc[ACC_W-2:SAT_MSB]);

    // Clamp to the signed 11-bit range, otherwise take acc/128.
    always_comb begin
        o_sat = r_acc[SAT_MSB:SAT_LSB];
        if (w_pos_ovf) begin
            o_sat = {1'b0, {(LUT_AW-1){1'b1}}};
        end else if (w_neg_ovf) begin
            o_sat = {1'b1, {(LUT_AW-1){1'b0}}};
        end
    end

endmodule

// File: rtl/snn_ram.sv
// Single-port RAM/ROM with registered read, used for weights, LUT and hidden store.
// Latency: q reflects addr one clock later; write happens on the clock edge when we=1.
// Backpressure: none, accepts an access every cycle.
module snn_ram #(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Contents named by INIT_FILE are bound into r_mem by the device programming flow.
    if (INIT_FILE != "") begin : g_preloaded
    end

    // Synchronous write and registered read-before-write.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= data;
        end
        q <= r_mem[addr];
    end

endmodule

// File: rtl/snn_core.sv
// 784->32->10 fully-connected classifier over a 1-bit image; reports the arg-max digit.
// Latency: ~25.5k clk from start to the done pulse (787 clk per hidden neuron, 35 per output).
// Backpressure: none; start is only honoured in IDLE, pulses while busy are dropped.
module snn_core
    import snn_pkg::*;
#(
    parameter string HW_FILE  = "rom_hidden_weight_contents.txt",
    parameter string OW_FILE  = "rom_output_weight_contents.txt",
    parameter string ACT_FILE = "rom_act_func_lut_contents.txt"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              q_input,
    output logic [PIX_AW-1:0] addr_input_unit,
    output logic [OUT_AW-1:0] digit,
    output logic              done
);

    localparam logic [PIX_AW-1:0] PIX_LAST = PIX_AW'(N_IN - 1);
    localparam logic [HID_AW-1:0] HID_LAST = HID_AW'(N_HID - 1);
    localparam logic [OUT_AW-1:0] OUT_LAST = OUT_AW'(N_OUT - 1);
    // ACT phase: cycle 0 finishes the last MAC, 1 addresses the LUT, 2 consumes the LUT output.
    localparam logic [1:0]        ACT_LAST = 2'd2;

    state_t              r_state;
    state_t              w_next;
    logic                w_clr;
    logic                w_hid_we;
    logic                w_score;

    logic [PIX_AW-1:0]   r_pix;
    logic [HW_AW-1:0]    r_hw_addr;
    logic [HID_AW-1:0]   r_h;
    logic [HID_AW-1:0]   r_j;
    logic [OUT_AW-1:0]   r_d;
    logic [OW_AW-1:0]    r_ow_addr;
    logic [1:0]          r_act;
    logic                r_mac_en;
    logic                r_out_phase;
    logic [W_W-1:0]      r_max;
    logic [OUT_AW-1:0]   r_arg;
    logic [OUT_AW-1:0]   r_digit;
    logic                r_done;

    logic [W_W-1:0]      w_hw_q;
    logic [W_W-1:0]      w_ow_q;
    logic [W_W-1:0]      w_lut_q;
    logic [W_W-1:0]      w_hid_q;
    logic [HID_AW-1:0]   w_hid_addr;
    logic [W_W-1:0]      w_w;
    logic [W_W-1:0]      w_x;
    logic [LUT_AW-1:0]   w_sat;
    logic                w_in_act;

    snn_ram #(.DATA_WIDTH(W_W), .ADDR_WIDTH(HW_AW), .INIT_FILE(HW_FILE)) u_rom_hw (
        .clk  (clk),
        .data ('0),
        .addr (r_hw_addr),
        .we   (1'b0),
        .q    (w_hw_q)
    );

    snn_ram #(.DATA_WIDTH(W_W), .ADDR_WIDTH(OW_AW), .INIT_FILE(OW_FILE)) u_rom_ow (
        .clk  (clk),
        .data ('0),
        .addr (r_ow_addr),
        .we   (1'b0),
        .q    (w_ow_q)
    );

    snn_ram #(.DATA_WIDTH(W_W), .ADDR_WIDTH(LUT_AW), .INIT_FILE(ACT_FILE)) u_rom_act (
        .clk  (clk),
        .data ('0),
        .addr (lut_addr(w_sat)),
        .we   (1'b0),
        .q    (w_lut_q)
    );

    // Hidden activations: written at h during HID_ACT, read at j during OUT_MAC.
    assign w_hid_addr = w_hid_we ? r_h : r_j;

    snn_ram #(.DATA_WIDTH(W_W), .ADDR_WIDTH(HID_AW), .INIT_FILE("")) u_ram_hid (
        .clk  (clk),
        .data (w_lut_q),
        .addr (w_hid_addr),
        .we   (w_hid_we),
        .q    (w_hid_q)
    );

    // Operands arrive one cycle after their address; r_out_phase selects the layer.
    assign w_w = r_out_phase ? w_ow_q  : w_hw_q;
    assign w_x = r_out_phase ? w_hid_q : (q_input ? 8'h7F : 8'h00);

    snn_mac u_mac (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_clr),
        .i_en    (r_mac_en),
        .i_w     (w_w),
        .i_x     (w_x),
        .o_sat   (w_sat)
    );

    assign w_in_act = (r_state == S_HID_ACT) || (r_state == S_OUT_ACT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus per-cycle strobes: accumulator clear, hidden write, output scoring.
    always_comb begin
        w_next   = r_state;
        w_clr    = 1'b0;
        w_hid_we = 1'b0;
        w_score  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_HID_MAC;
                    w_clr  = 1'b1;
                end
            end
            S_HID_MAC: begin
                if (r_pix == PIX_LAST) begin
                    w_next = S_HID_ACT;
                end
            end
            S_HID_ACT: begin
                if (r_act == ACT_LAST) begin
                    w_hid_we = 1'b1;
                    w_clr    = 1'b1;
                    w_next   = (r_h == HID_LAST) ? S_OUT_MAC : S_HID_MAC;
                end
            end
            S_OUT_MAC: begin
                if (r_j == HID_LAST) begin
                    w_next = S_OUT_ACT;
                end
            end
            S_OUT_ACT: begin
                if (r_act == ACT_LAST) begin
                    w_score = 1'b1;
                    w_clr   = 1'b1;
                    w_next  = (r_d == OUT_LAST) ? S_DONE : S_OUT_MAC;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Address counters, MAC enable pipeline and running arg-max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix       <= '0;
            r_hw_addr   <= '0;
            r_h         <= '0;
            r_j         <= '0;
            r_d         <= '0;
            r_ow_addr   <= '0;
            r_act       <= '0;
            r_mac_en    <= 1'b0;
            r_out_phase <= 1'b0;
            r_max       <= '0;
            r_arg       <= '0;
        end else begin
            r_mac_en    <= (r_state == S_HID_MAC) || (r_state == S_OUT_MAC);
            r_out_phase <= (r_state == S_OUT_MAC);
            r_act       <= (w_in_act && (r_act != ACT_LAST)) ? r_act + 1'b1 : 2'd0;

            if ((r_state == S_IDLE) && start) begin
                r_pix     <= '0;
                r_hw_addr <= '0;
                r_h       <= '0;
                r_j       <= '0;
                r_d       <= '0;
                r_ow_addr <= '0;
            end

            // Hidden weight address runs straight through h*784+p without a multiplier.
            if (r_state == S_HID_MAC) begin
                r_hw_addr <= r_hw_addr + 1'b1;
                r_pix     <= (r_pix == PIX_LAST) ? '0 : r_pix + 1'b1;
            end

            if (w_hid_we) begin
                r_h <= r_h + 1'b1;
            end

            // j wraps 31->0 naturally, ready for the next digit.
            if (r_state == S_OUT_MAC) begin
                r_ow_addr <= r_ow_addr + 1'b1;
                r_j       <= r_j + 1'b1;
            end

            // Strictly greater replaces, so ties keep the lowest digit.
            if (w_score) begin
                r_d <= r_d + 1'b1;
                if ((r_d == '0) || (w_lut_q > r_max)) begin
                    r_max <= w_lut_q;
                    r_arg <= r_d;
                end
            end
        end
    end

    // Result register and one-cycle done pulse; digit holds until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_digit <= r_arg;
            end
        end
    end

    assign addr_input_unit = r_pix;
    assign digit           = r_digit;
    assign done            = r_done;

endmodule

// File: tb/tb_snn_core.sv
// Randomised bench for snn_core with a queue-based scoreboard and a network-level reference model.
// Latency: each classification takes ~25.5k clk; the run finishes well within its cycle bounds.
// Backpressure: n/a.
module tb_snn_core;
    import snn_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              q_input;
    logic [PIX_AW-1:0] addr_input_unit;
    logic [OUT_AW-1:0] digit;
    logic              done;

    logic                  mac_rst_n;
    logic                  mac_clr;
    logic                  mac_en;
    logic signed [W_W-1:0] mac_w;
    logic signed [W_W-1:0] mac_x;
    logic [LUT_AW-1:0]     mac_sat;

    always #5 clk = ~clk;

    snn_core dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .q_input         (q_input),
        .addr_input_unit (addr_input_unit),
        .digit           (digit),
        .done            (done)
    );

    snn_mac u_mac (
        .i_clk   (clk),
        .i_rst_n (mac_rst_n),
        .i_clr   (mac_clr),
        .i_en    (mac_en),
        .i_w     (mac_w),
        .i_x     (mac_x),
        .o_sat   (mac_sat)
    );

    byte               hw  [N_IN*N_HID];
    byte               ow  [N_HID*N_OUT];
    byte unsigned      lut [2**LUT_AW];
    logic [N_IN-1:0]   cur_img;
    int                exp_q[$];
    int                n_cmp  = 0;
    int                n_bad  = 0;
    int                n_done = 0;
    bit                addr_bad = 1'b0;

    // Image RAM: one-cycle registered read of the current picture.
    always @(posedge clk) begin
        if (addr_input_unit >= PIX_AW'(N_IN)) addr_bad <= 1'b1;
        q_input <= (addr_input_unit < PIX_AW'(N_IN)) ? cur_img[addr_input_unit] : 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // floor(acc/128) clamped to the signed 11-bit range
    function automatic int rect(input longint acc);
        longint s;
        s = acc >>> 7;
        if (s > 1023)  s = 1023;
        if (s < -1024) s = -1024;
        return int'(s);
    endfunction

    function automatic int activ(input longint acc);
        return int'(lut[rect(acc) + 1024]);
    endfunction

    function automatic int classify(input logic [N_IN-1:0] img);
        int     hid [N_HID];
        longint acc;
        int     best;
        int     arg;
        int     o;
        for (int h = 0; h < N_HID; h++) begin
            acc = 0;
            for (int p = 0; p < N_IN; p++)
                if (img[p]) acc += longint'(hw[h*N_IN + p]) * 127;
            hid[h] = activ(acc);
        end
        best = -1;
        arg  = 0;
        for (int d = 0; d < N_OUT; d++) begin
            acc = 0;
            for (int h = 0; h < N_HID; h++)
                acc += longint'(ow[d*N_HID + h]) * longint'(byte'(hid[h]));
            o = activ(acc);
            if (o > best) begin
                best = o;
                arg  = d;
            end
        end
        return arg;
    endfunction

    function automatic logic [N_IN-1:0] rand_img();
        logic [N_IN-1:0] v;
        for (int p = 0; p < N_IN; p++) v[p] = ($urandom_range(0, 2) == 0);
        return v;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done with a hard bound; optionally throws stray start pulses while busy.
    task automatic wait_done(input string name, input bit spur, output int cyc);
        bit seen;
        int k;
        seen = 1'b0;
        for (k = 1; k <= 60000; k++) begin
            @(negedge clk);
            start = spur && (k == 40 || k == 5000 || k == 17000);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({name, "_done_in_time"}, int'(seen), 1);
        cyc = k;
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    initial begin
        bit prev_done;
        int e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                n_done++;
                check("done_single_cycle", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: digit=%0d with no start outstanding", digit);
                end else begin
                    e = exp_q.pop_front();
                    check("digit", int'(digit), e);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        logic [N_IN-1:0] img_a;
        logic [N_IN-1:0] img_c;
        int exp_a;
        int exp_b;
        int exp_c;
        int cyc;
        longint acc;

        rst_n     = 1'b0;
        start     = 1'b0;
        mac_rst_n = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        mac_w     = '0;
        mac_x     = '0;
        cur_img   = '0;

        for (int i = 0; i < N_IN*N_HID; i++) begin
            hw[i] = byte'($urandom);
            dut.u_rom_hw.r_mem[i] = hw[i];
        end
        for (int i = 0; i < N_HID*N_OUT; i++) begin
            ow[i] = byte'($urandom);
            dut.u_rom_ow.r_mem[i] = ow[i];
        end
        for (int i = 0; i < 2**LUT_AW; i++) begin
            lut[i] = 8'($urandom);
            dut.u_rom_act.r_mem[i] = lut[i];
        end

        repeat (3) @(negedge clk);
        check("reset_done",  int'(done), 0);
        check("reset_digit", int'(digit), 0);
        check("reset_addr",  int'(addr_input_unit), 0);

        // MAC unit: positive ramp, saturation both ways, and the zero point.
        mac_rst_n = 1'b1;
        @(negedge clk);
        mac_clr = 1'b1;
        @(negedge clk);
        mac_clr = 1'b0;
        mac_en  = 1'b1;
        mac_w   = 8'sd127;
        mac_x   = 8'sd127;
        for (int k = 1; k <= N_IN; k++) begin
            @(negedge clk);
            if (k == 3) check("mac_3_products", int'(mac_sat), rect(127*127*3) & 'h7FF);
        end
        mac_en = 1'b0;
        acc = longint'(127*127) * N_IN;
        check("mac_pos_sat", int'(mac_sat), rect(acc) & 'h7FF);

        mac_clr = 1'b1;
        mac_w   = -8'sd128;
        @(negedge clk);
        mac_clr = 1'b0;
        mac_en  = 1'b1;
        for (int k = 1; k <= N_IN; k++) @(negedge clk);
        mac_en = 1'b0;
        acc = longint'(-128*127) * N_IN;
        check("mac_neg_sat", int'(mac_sat), rect(acc) & 'h7FF);

        mac_clr = 1'b1;
        @(negedge clk);
        mac_clr = 1'b0;
        check("mac_zero_sat", int'(mac_sat), 0);
        check("mac_zero_lut_addr", int'(lut_addr(mac_sat)), 1024);

        // Run A: random image with stray start pulses while busy.
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        img_a = rand_img();
        exp_a = classify(img_a);
        exp_b = classify('0);
        cur_img = img_a;
        exp_q.push_back(exp_a);
        pulse_start();
        wait_done("run_a", 1'b1, cyc);
        check("run_a_latency_le_26000", int'(cyc <= 26000), 1);

        // Run B: all-zero image started in the same cycle done is seen.
        cur_img = '0;
        exp_q.push_back(exp_b);
        pulse_start();
        wait_done("run_b", 1'b0, cyc);
        check("done_count_after_b", n_done, 2);

        // Run C: aborted by reset early in the hidden layer; no result expected.
        img_c = rand_img();
        exp_c = classify(img_c);
        cur_img = img_c;
        pulse_start();
        repeat (1500) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_done",  int'(done), 0);
        check("abort_digit", int'(digit), 0);
        check("abort_addr",  int'(addr_input_unit), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run D: same image after the abort.
        exp_q.push_back(exp_c);
        pulse_start();
        wait_done("run_d", 1'b0, cyc);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("done_count_total", n_done, 3);
        check("addr_in_range", int'(addr_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
